// File: rtl/serial_scan_scheduler.sv
// Round-robin scan sequencer: drives latch/pulse/sel for CHAINS shift-register chains on one serial input.
// Optional macro CHANGE_ONLY_EN: a result is posted only when a chain's word differs from its previous scan.
module serial_scan_scheduler #(
    parameter int BITS        = 8,
    parameter int CHAINS      = 2,
    parameter int HALF_PERIOD = 4,
    parameter int GAP         = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    data_in,
    output logic                    latch,
    output logic                    pulse,
    output logic [CHAINS-1:0]       sel,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [BITS-1:0]         result_data,
    output logic [$clog2(CHAINS):0] result_chain,
    output logic                    overrun
);
    localparam int CW      = $clog2(CHAINS) + 1;
    localparam int CNT_MAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LO,
        S_HI,
        S_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              latch_half_q, latch_half_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [BITS-1:0]   shreg_q, shreg_d;
    logic              valid_q, valid_d;
    logic [BITS-1:0]   data_q, data_d;
    logic [CW-1:0]     chain_q, chain_d;
    logic              overrun_q, overrun_d;
    logic              latch_q, latch_d;
    logic              pulse_q, pulse_d;
    logic [CHAINS-1:0] sel_q, sel_d;
    logic              tick;
    logic              post;

`ifdef CHANGE_ONLY_EN
    localparam int IW = (CHAINS > 1) ? $clog2(CHAINS) : 1;
    logic [BITS-1:0] last_q [CHAINS];
    logic [BITS-1:0] last_d [CHAINS];
`endif

    assign tick = (cnt_q == CNT_W'(HALF_PERIOD - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        latch_half_d = latch_half_q;
        ptr_d        = ptr_q;
        shreg_d      = shreg_q;
        valid_d      = valid_q & ~result_ready;
        data_d       = data_q;
        chain_d      = chain_q;
        overrun_d    = 1'b0;
        post         = 1'b1;
`ifdef CHANGE_ONLY_EN
        last_d       = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = S_LATCH;
            end
            // LATCH spans two phases; the counter wraps once in between.
            S_LATCH: begin
                if (tick) begin
                    cnt_d        = '0;
                    latch_half_d = 1'b1;
                    if (latch_half_q) state_d = S_LO;
                end
            end
            S_LO: begin
                if (tick) begin
                    shreg_d = {shreg_q[BITS-2:0], data_in};
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (tick) begin
                    if (bit_cnt_q == BW'(BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = S_LO;
                    end
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                ptr_d   = (ptr_q == CW'(CHAINS - 1)) ? '0 : ptr_q + CW'(1);
`ifdef CHANGE_ONLY_EN
                post                  = (shreg_q != last_q[ptr_q[IW-1:0]]);
                last_d[ptr_q[IW-1:0]] = shreg_q;
`endif
                // A held, unaccepted result wins; the new word is dropped and flagged.
                if (post) begin
                    if (valid_q && !result_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                        chain_d = ptr_q;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) state_d = enable ? S_LATCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == S_LATCH) begin
                latch_half_d = 1'b0;
                bit_cnt_d    = '0;
            end
        end

        // Board strobes are registered from the next state so they never glitch.
        latch_d = (state_d == S_LATCH);
        pulse_d = (state_d == S_HI);
        sel_d   = (state_d inside {S_LATCH, S_LO, S_HI}) ? (CHAINS'(1) << ptr_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            latch_half_q <= 1'b0;
            ptr_q        <= '0;
            shreg_q      <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            chain_q      <= '0;
            overrun_q    <= 1'b0;
            latch_q      <= 1'b0;
            pulse_q      <= 1'b0;
            sel_q        <= '0;
`ifdef CHANGE_ONLY_EN
            for (int i = 0; i < CHAINS; i++) last_q[i] <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            latch_half_q <= latch_half_d;
            ptr_q        <= ptr_d;
            shreg_q      <= shreg_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            chain_q      <= chain_d;
            overrun_q    <= overrun_d;
            latch_q      <= latch_d;
            pulse_q      <= pulse_d;
            sel_q        <= sel_d;
`ifdef CHANGE_ONLY_EN
            last_q       <= last_d;
`endif
        end
    end

    assign latch        = latch_q;
    assign pulse        = pulse_q;
    assign sel          = sel_q;
    assign result_valid = valid_q;
    assign result_data  = data_q;
    assign result_chain = chain_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_serial_scan_scheduler.sv
// Bench for serial_scan_scheduler: two emulated shift-register chains, a scan-timeline model
// checked every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_serial_scan_scheduler;
    localparam int BITS   = 8;
    localparam int CHAINS = 2;
    localparam int HP     = 2;
    localparam int GAP    = 4;
    localparam int L      = (2 + 2 * BITS) * HP;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       enable       = 1'b0;
    logic       result_ready = 1'b0;
    logic       data_in;
    logic       latch;
    logic       pulse;
    logic [1:0] sel;
    logic       result_valid;
    logic [7:0] result_data;
    logic [1:0] result_chain;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] word [2] = '{8'h00, 8'h00};
    logic [7:0] creg [2] = '{8'h00, 8'h00};
    logic       pulse_prev = 1'b0;

    serial_scan_scheduler #(
        .BITS(BITS), .CHAINS(CHAINS), .HALF_PERIOD(HP), .GAP(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .data_in(data_in),
        .latch(latch),
        .pulse(pulse),
        .sel(sel),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data(result_data),
        .result_chain(result_chain),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Board chains: parallel load while latch is high, shift on each rising pulse.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (latch) creg[c] = word[c];
            else if (pulse && !pulse_prev) creg[c] = {creg[c][6:0], 1'b0};
        end
        pulse_prev = pulse;
    end
    assign data_in = (sel[0] & creg[0][7]) | (sel[1] & creg[1][7]);

    // Timeline model: m_off counts clk cycles since LATCH entry (DONE at L, GAP up to L+GAP).
    bit         m_run     = 1'b0;
    int         m_off     = 0;
    int         m_ptr     = 0;
    bit         m_valid   = 1'b0;
    logic [7:0] m_data    = 8'h00;
    int         m_chain   = 0;
    bit         m_overrun = 1'b0;
    logic [7:0] m_word    = 8'h00;
    logic [7:0] m_last [2] = '{8'h00, 8'h00};

    always @(posedge clk) begin : model
        bit do_post;
        if (reset) begin
            m_run = 0; m_off = 0; m_ptr = 0; m_valid = 0; m_data = 0;
            m_chain = 0; m_overrun = 0; m_last[0] = 0; m_last[1] = 0;
        end else begin
            m_overrun = 0;
            if (m_valid && result_ready) m_valid = 0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1; m_off = 0; m_word = word[m_ptr];
                end
            end else if (m_off == L) begin
                do_post = 1;
`ifdef CHANGE_ONLY_EN
                do_post = (m_word != m_last[m_ptr]);
                m_last[m_ptr] = m_word;
`endif
                if (do_post) begin
                    if (m_valid) m_overrun = 1;
                    else begin
                        m_valid = 1; m_data = m_word; m_chain = m_ptr;
                    end
                end
                m_ptr = (m_ptr + 1) % CHAINS;
                m_off++;
            end else if (m_off == L + GAP) begin
                if (enable) begin
                    m_off = 0; m_word = word[m_ptr];
                end else begin
                    m_run = 0;
                end
            end else begin
                m_off++;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        bit         exp_latch;
        bit         exp_pulse;
        logic [1:0] exp_sel;
        exp_latch = m_run && (m_off < 2 * HP);
        exp_pulse = m_run && (m_off >= 2 * HP) && (m_off < L) && (((m_off - 2 * HP) / HP) % 2 == 1);
        exp_sel   = (m_run && (m_off < L)) ? 2'(1 << m_ptr) : 2'b00;
        check_output("strobes", {latch, pulse, sel}, {exp_latch, exp_pulse, exp_sel});
        check_output("result_valid", result_valid, m_valid);
        check_output("result", {result_chain, result_data}, {m_chain[1:0], m_data});
        check_output("overrun", overrun, m_overrun);
    end

    // which: 0 latch, 1 pulse, 2 result_valid, 3 overrun; cycles = negedges waited.
    task automatic wait_for(input int which, input int budget, input string name, output int cycles);
        bit hit;
        hit = 0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge clk);
            cycles++;
            case (which)
                0: hit = latch;
                1: hit = pulse;
                2: hit = result_valid;
                default: hit = overrun;
            endcase
        end
        check_output({"wait_", name}, hit, 1);
    endtask

    task automatic apply_stimulus();
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        result_ready = ($urandom_range(0, 9) < 7);
        if ((!m_run || m_off >= L) && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0: word[$urandom_range(0, 1)] = 8'h5A;
                1: word[$urandom_range(0, 1)] = 8'hA5;
                default: word[$urandom_range(0, 1)] = 8'($urandom);
            endcase
        end
        if ($urandom_range(0, 799) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            #2 reset = 1'b0;
        end
    endtask

    initial begin : stimulus
        int n;
        int cnt0;
        int cnt1;
        int ovr;
        repeat (2) @(negedge clk);
        check_output("reset_strobes", {latch, pulse, sel, result_valid, overrun}, 0);
        check_output("reset_result", {result_chain, result_data}, 0);

        // Abort a chain0 scan mid-HI with reset.
        word[0] = 8'hA5;
        word[1] = 8'h3C;
        result_ready = 1'b1;
        enable = 1'b1;
        reset = 1'b0;
        wait_for(1, 100, "pulse_t1", n);
        #2 reset = 1'b1;
        #1 check_output("t1_abort", {latch, pulse, sel, result_valid}, 0);
        @(negedge clk);
        #2 reset = 1'b0;

        wait_for(0, 10, "latch_t2", n);
        check_output("t1_restart_sel", sel, 2'b01);
        wait_for(2, 60, "valid_t2", n);
        check_output("t2_latency", n, 37);
        check_output("t2_data", result_data, 8'hA5);
        check_output("t2_chain", result_chain, 0);

        wait_for(0, 60, "latch_t3", n);
        check_output("t3_sel_latch", sel, 2'b10);
        wait_for(1, 20, "pulse_t3", n);
        check_output("t3_sel_shift", sel, 2'b10);
        wait_for(2, 60, "valid_t3", n);
        check_output("t3_data", result_data, 8'h3C);
        check_output("t3_chain", result_chain, 1);
        wait_for(0, 60, "latch_t3b", n);
        check_output("t3_next_sel", sel, 2'b01);

        // Two unaccepted scans from a fresh start: the second must overrun.
        #2 reset = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        #2 reset = 1'b0;
        wait_for(3, 200, "overrun_t4", n);
        check_output("t4_held_data", result_data, 8'hA5);
        check_output("t4_held_chain", result_chain, 0);
        check_output("t4_held_valid", result_valid, 1);
        word[0] = 8'h81;
        result_ready = 1'b1;
        @(negedge clk);
        check_output("t4_overrun_pulse", overrun, 0);
        check_output("t4_drain", result_valid, 0);

        // Drop enable mid-scan: scan completes, then the scheduler idles.
        wait_for(0, 60, "latch_t5", n);
        check_output("t5_sel", sel, 2'b01);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_for(2, 60, "valid_t5", n);
        check_output("t5_data", result_data, 8'h81);
        check_output("t5_chain", result_chain, 0);
        cnt0 = 0;
        repeat (40) begin
            @(negedge clk);
            if (latch || sel != 2'b00) cnt0++;
        end
        check_output("t5_idle", cnt0, 0);

`ifdef CHANGE_ONLY_EN
        #2 reset = 1'b1;
        @(negedge clk);
        word[0] = 8'h5A;
        word[1] = 8'h11;
        result_ready = 1'b1;
        enable = 1'b1;
        #2 reset = 1'b0;
        cnt0 = 0; cnt1 = 0; ovr = 0;
        repeat (140) begin
            @(negedge clk);
            if (result_valid && result_chain == 2'd0) cnt0++;
            if (result_valid && result_chain == 2'd1) cnt1++;
            if (overrun) ovr++;
        end
        check_output("t6_chain0_results", cnt0, 1);
        check_output("t6_chain1_results", cnt1, 1);
        check_output("t6_overruns", ovr, 0);
`else
        cnt1 = 0;
        ovr = 0;
`endif

        enable = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            apply_stimulus();
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
